// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller request path.
package mem_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 30;

  localparam logic REQ_WRITE = 1'b1;
  localparam logic REQ_READ  = 1'b0;

  // Default-width request record; the front end uses the same field order
  // for its queue entries and the scheduler-facing head fields.
  typedef struct packed {
    logic                      req_type;
    logic [DEF_ADDR_WIDTH-1:0] address;
    logic [DEF_DATA_WIDTH-1:0] data;
  } req_t;

endpackage

// File: rtl/req_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on o_rdata.
// Pointers carry one extra MSB so full and empty are distinguishable.
module req_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/req_front_end.sv
// Host-facing request front end: queues host requests for the scheduler,
// limits outstanding work, and turns in-order completions into done pulses.
module req_front_end
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH   = 16,
  parameter int MAX_INFLIGHT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_request_type,
  input  logic [ADDR_WIDTH-1:0] in_request_address,
  input  logic [DATA_WIDTH-1:0] in_request_data,
  output logic                  out_busy,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_type,
  output logic [ADDR_WIDTH-1:0] req_address,
  output logic [DATA_WIDTH-1:0] req_data,
  input  logic                  rsp_valid,
  input  logic                  rsp_type,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  write_done,
  output logic                  read_done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  err_overflow,
  output logic                  err_spurious
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  // Same field order as req_t, sized by this instance's parameters.
  typedef struct packed {
    logic                  req_type;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t              w_push_entry;
  entry_t              w_head;
  logic [ENTRY_W-1:0]  w_head_bits;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_busy;
  logic                w_accept;
  logic                w_pop;
  logic                w_complete;
  logic                w_inflight_nz;

  logic [IW-1:0]         r_inflight;
  logic                  r_write_done;
  logic                  r_read_done;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_err_overflow;
  logic                  r_err_spurious;

  // Busy depends only on registered state, so it is stable all cycle.
  assign w_inflight_nz = (r_inflight != '0);
  assign w_busy        = w_fifo_full || (r_inflight == IW'(MAX_INFLIGHT));
  assign w_accept      = in_valid && !w_busy;
  assign w_pop         = !w_fifo_empty && req_ready;
  assign w_complete    = rsp_valid && w_inflight_nz;

  assign w_push_entry.req_type = in_request_type;
  assign w_push_entry.address  = in_request_address;
  assign w_push_entry.data     = in_request_data;

  req_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_head = w_head_bits;

  // Head fields are forced to zero while nothing is queued.
  assign out_busy    = w_busy;
  assign req_valid   = !w_fifo_empty;
  assign req_type    = w_head.req_type & req_valid;
  assign req_address = w_head.address & {ADDR_WIDTH{req_valid}};
  assign req_data    = w_head.data & {DATA_WIDTH{req_valid}};

  // Outstanding-request counter: accepted but not yet completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else if (w_accept && !w_complete) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (!w_accept && w_complete) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

  // Completion pulses, read data capture and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_done   <= 1'b0;
      r_read_done    <= 1'b0;
      r_data_out     <= '0;
      r_err_overflow <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_write_done <= w_complete && (rsp_type == REQ_WRITE);
      r_read_done  <= w_complete && (rsp_type == REQ_READ);
      if (w_complete && (rsp_type == REQ_READ)) r_data_out <= rsp_data;
      if (in_valid && w_busy)        r_err_overflow <= 1'b1;
      if (rsp_valid && !w_inflight_nz) r_err_spurious <= 1'b1;
    end
  end

  assign write_done   = r_write_done;
  assign read_done    = r_read_done;
  assign data_out     = r_data_out;
  assign err_overflow = r_err_overflow;
  assign err_spurious = r_err_spurious;

endmodule
